// File: rtl/xbar_out_stage_if.sv
// rtl/xbar_out_stage_if.sv - phit/select inputs and registered outputs of the crossbar output stage
interface xbar_out_stage_if #(
    parameter int N_PORTS = 4,
    parameter int PHIT_W  = 35,
    parameter int CNT_W   = 16
);
    logic [N_PORTS*PHIT_W-1:0]  in_data;
    logic [N_PORTS*N_PORTS-1:0] in_sel;
    logic                       clear_err;
    logic [N_PORTS*PHIT_W-1:0]  out_data;
    logic [N_PORTS-1:0]         err_port;
    logic [CNT_W-1:0]           err_cnt;

    modport master (
        output in_data, in_sel, clear_err,
        input  out_data, err_port, err_cnt
    );

    modport slave (
        input  in_data, in_sel, clear_err,
        output out_data, err_port, err_cnt
    );
endinterface

// File: rtl/xbar_out_stage.sv
// rtl/xbar_out_stage.sv - crossbar with per-output packet ownership FSM, registered phits and error tracking
module xbar_out_stage #(
    parameter int N_PORTS = 4,
    parameter int PHIT_W  = 35,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    xbar_out_stage_if.slave      bus
);
    localparam int OW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int B_VLD = PHIT_W - 1;
    localparam int B_SOP = PHIT_W - 2;
    localparam int B_EOP = PHIT_W - 3;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t              r_state     [N_PORTS];
    logic [OW-1:0]       r_owner     [N_PORTS];
    logic [PHIT_W-1:0]   r_data      [N_PORTS];
    logic [N_PORTS-1:0]  r_err_port;
    logic [CNT_W-1:0]    r_err_cnt;

    state_t              w_nxt_state [N_PORTS];
    logic [OW-1:0]       w_nxt_owner [N_PORTS];
    logic [PHIT_W-1:0]   w_nxt_data  [N_PORTS];
    logic [N_PORTS-1:0]  w_err;
    logic [N_PORTS-1:0]  w_req       [N_PORTS];
    logic [N_PORTS-1:0]  w_nxt_err_port;
    logic [CNT_W-1:0]    w_nxt_err_cnt;

    // w_req[o][i]: input i presents a valid phit addressed to output o
    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                w_req[o][i] = bus.in_sel[i*N_PORTS + o] & bus.in_data[i*PHIT_W + B_VLD];
            end
        end
    end

    always_comb begin : p_next
        logic              one;
        logic              multi;
        logic [OW-1:0]     first;
        logic              own_req;
        logic              other_req;
        logic [PHIT_W-1:0] ph;
        one       = 1'b0;
        multi     = 1'b0;
        first     = '0;
        own_req   = 1'b0;
        other_req = 1'b0;
        ph        = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            w_nxt_state[o] = r_state[o];
            w_nxt_owner[o] = r_owner[o];
            w_nxt_data[o]  = '0;
            w_err[o]       = 1'b0;
            one            = 1'b0;
            multi          = 1'b0;
            first          = '0;
            ph             = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                if (w_req[o][i]) begin
                    if (one || multi) begin
                        one   = 1'b0;
                        multi = 1'b1;
                    end else begin
                        one   = 1'b1;
                        first = OW'(i);
                    end
                end
            end
            own_req   = w_req[o][r_owner[o]];
            other_req = |(w_req[o] & ~(N_PORTS'(1) << r_owner[o]));
            case (r_state[o])
                ST_IDLE: begin
                    if (multi) begin
                        w_err[o] = 1'b1;
                    end else if (one) begin
                        ph = bus.in_data[first*PHIT_W +: PHIT_W];
                        if (ph[B_SOP]) begin
                            w_nxt_data[o] = ph;
                            if (!ph[B_EOP]) begin
                                w_nxt_state[o] = ST_BUSY;
                                w_nxt_owner[o] = first;
                            end
                        end else begin
                            w_err[o] = 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    // Intruders are dropped and flagged; the owner's phit is handled independently
                    if (other_req) begin
                        w_err[o] = 1'b1;
                    end
                    if (own_req) begin
                        ph = bus.in_data[r_owner[o]*PHIT_W +: PHIT_W];
                        w_nxt_data[o] = ph;
                        if (ph[B_EOP]) begin
                            w_nxt_state[o] = ST_IDLE;
                        end else if (ph[B_SOP]) begin
                            w_err[o] = 1'b1;
                        end
                    end
                end
                default: begin
                    w_nxt_state[o] = ST_IDLE;
                end
            endcase
        end
    end

    // A same-cycle error beats clear_err, so the cleared values restart from this cycle's errors
    always_comb begin
        w_nxt_err_port = r_err_port | w_err;
        w_nxt_err_cnt  = r_err_cnt;
        if (bus.clear_err) begin
            w_nxt_err_port = w_err;
            w_nxt_err_cnt  = (|w_err) ? CNT_W'(1) : '0;
        end else if ((|w_err) && (r_err_cnt != {CNT_W{1'b1}})) begin
            w_nxt_err_cnt = r_err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < N_PORTS; o++) begin
                r_state[o] <= ST_IDLE;
                r_owner[o] <= '0;
                r_data[o]  <= '0;
            end
            r_err_port <= '0;
            r_err_cnt  <= '0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                r_state[o] <= w_nxt_state[o];
                r_owner[o] <= w_nxt_owner[o];
                r_data[o]  <= w_nxt_data[o];
            end
            r_err_port <= w_nxt_err_port;
            r_err_cnt  <= w_nxt_err_cnt;
        end
    end

    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            bus.out_data[o*PHIT_W +: PHIT_W] = r_data[o];
        end
    end

    assign bus.err_port = r_err_port;
    assign bus.err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_xbar_out_stage.sv
// tb/tb_xbar_out_stage.sv - scoreboard bench for xbar_out_stage with a queue-based reference model
module tb_xbar_out_stage;
    localparam int N = 4;
    localparam int W = 35;
    localparam int C = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    xbar_out_stage_if #(.N_PORTS(N), .PHIT_W(W), .CNT_W(C)) bus ();

    xbar_out_stage #(.N_PORTS(N), .PHIT_W(W), .CNT_W(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [N*W-1:0] d;
        logic [N-1:0]   ep;
        logic [C-1:0]   ec;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] td [N];
    logic [N-1:0] ts [N];

    // Reference model state: which outputs carry an open packet and for whom
    bit m_busy  [N];
    int m_owner [N];
    logic [N-1:0] m_errp = '0;
    int m_cnt = 0;

    function automatic logic [W-1:0] ph(input bit v, input bit s, input bit e, input logic [31:0] p);
        return {v, s, e, p};
    endfunction

    task automatic clr_in();
        for (int i = 0; i < N; i++) begin
            td[i] = '0;
            ts[i] = '0;
        end
    endtask

    task automatic step(input bit rst, input bit clr);
        exp_t e;
        logic [N-1:0] err;
        int reqs[$];
        bit own_in, intr;
        @(negedge clk);
        reset = rst;
        bus.clear_err = clr;
        for (int i = 0; i < N; i++) begin
            bus.in_data[i*W +: W] = td[i];
            bus.in_sel[i*N +: N]  = ts[i];
        end
        e.d = '0;
        err = '0;
        if (rst) begin
            for (int o = 0; o < N; o++) m_busy[o] = 0;
            m_errp = '0;
            m_cnt  = 0;
        end else begin
            for (int o = 0; o < N; o++) begin
                reqs = {};
                for (int i = 0; i < N; i++)
                    if (ts[i][o] && td[i][W-1]) reqs.push_back(i);
                if (!m_busy[o]) begin
                    if (reqs.size() >= 2) err[o] = 1;
                    else if (reqs.size() == 1) begin
                        if (td[reqs[0]][W-2]) begin
                            e.d[o*W +: W] = td[reqs[0]];
                            if (!td[reqs[0]][W-3]) begin
                                m_busy[o]  = 1;
                                m_owner[o] = reqs[0];
                            end
                        end else err[o] = 1;
                    end
                end else begin
                    own_in = 0;
                    intr   = 0;
                    foreach (reqs[k]) begin
                        if (reqs[k] == m_owner[o]) own_in = 1;
                        else intr = 1;
                    end
                    if (intr) err[o] = 1;
                    if (own_in) begin
                        e.d[o*W +: W] = td[m_owner[o]];
                        if (td[m_owner[o]][W-3]) m_busy[o] = 0;
                        else if (td[m_owner[o]][W-2]) err[o] = 1;
                    end
                end
            end
            if (clr) begin
                m_errp = err;
                m_cnt  = (err != 0) ? 1 : 0;
            end else begin
                m_errp = m_errp | err;
                if (err != 0 && m_cnt < 65535) m_cnt++;
            end
        end
        e.ep = m_errp;
        e.ec = C'(m_cnt);
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (bus.out_data !== e.d) begin
                    n_fail++;
                    $display("FAIL out_data act=%h exp=%h", bus.out_data, e.d);
                end
                n_checks++;
                if (bus.err_port !== e.ep) begin
                    n_fail++;
                    $display("FAIL err_port act=%b exp=%b", bus.err_port, e.ep);
                end
                n_checks++;
                if (bus.err_cnt !== e.ec) begin
                    n_fail++;
                    $display("FAIL err_cnt act=%h exp=%h", bus.err_cnt, e.ec);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.clear_err = 1'b0;
        bus.in_data = '0;
        bus.in_sel  = '0;
        clr_in();
        step(1, 0);
        step(1, 0);

        // 1) four-phit packet in0 -> out0
        ts[0] = 4'b0001;
        td[0] = ph(1, 1, 0, 32'h6000_1234); step(0, 0);
        td[0] = ph(1, 0, 0, 32'h0000_1111); step(0, 0);
        td[0] = ph(1, 0, 0, 32'h0000_2222); step(0, 0);
        td[0] = ph(1, 0, 1, 32'h0000_3333); step(0, 0);
        clr_in(); step(0, 0);

        // 2) contention on out2
        ts[1] = 4'b0100; td[1] = ph(1, 1, 0, 32'hAAAA_0001);
        ts[2] = 4'b0100; td[2] = ph(1, 1, 0, 32'hBBBB_0002);
        step(0, 0);
        clr_in(); ts[1] = 4'b0100; td[1] = ph(1, 0, 1, 32'hAAAA_0003); step(0, 0);
        clr_in(); step(0, 1);

        // 3) intruder on an owned output, owner bubble in between
        ts[0] = 4'b0010; td[0] = ph(1, 1, 0, 32'h1000_0000); step(0, 0);
        ts[3] = 4'b0010; td[3] = ph(1, 1, 0, 32'h3333_0000);
        td[0] = ph(1, 0, 0, 32'h1000_0001); step(0, 0);
        td[0] = ph(0, 0, 0, 32'h0); step(0, 0);
        td[3] = '0; ts[3] = '0;
        td[0] = ph(1, 0, 1, 32'h1000_0002); step(0, 0);
        clr_in(); step(0, 0);

        // 4) orphan, then single-phit packet
        ts[2] = 4'b1000; td[2] = ph(1, 0, 0, 32'h2222_0000); step(0, 0);
        td[2] = ph(1, 1, 1, 32'h2222_0001); step(0, 0);
        clr_in(); step(0, 1);

        // missing eop inside an open packet
        ts[1] = 4'b0001; td[1] = ph(1, 1, 0, 32'h5555_0000); step(0, 0);
        td[1] = ph(1, 1, 0, 32'h5555_0001); step(0, 0);
        td[1] = ph(1, 0, 1, 32'h5555_0002); step(0, 0);
        clr_in(); step(0, 1);

        // random traffic, occasional multi-bit selects
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                ts[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, N - 1));
                td[i] = ph($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                           $urandom_range(0, 2) == 0, $urandom);
            end
            step(0, $urandom_range(0, 99) == 0);
        end
        clr_in(); step(1, 0);

        // 5) saturate err_cnt with continuous contention
        ts[0] = 4'b0001; td[0] = ph(1, 1, 0, 32'h1);
        ts[1] = 4'b0001; td[1] = ph(1, 1, 0, 32'h2);
        for (int c = 0; c < 70000; c++) step(0, 0);
        step(0, 1);
        clr_in(); step(0, 1);
        step(0, 0);

        // 6) reset mid-packet, then owner's eop becomes an orphan
        ts[0] = 4'b0001; td[0] = ph(1, 1, 0, 32'h7000_0000); step(0, 0);
        td[0] = ph(1, 0, 0, 32'h7000_0001); step(0, 0);
        clr_in(); step(1, 0);
        ts[0] = 4'b0001; td[0] = ph(1, 0, 1, 32'h7000_0002); step(0, 0);
        clr_in(); step(0, 0);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain act=%0d exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
